// File: rtl/btn_debounce.sv
// Button debouncer: synchronizes raw buttons and the slow divider clock, then
// accepts a level change only after STABLE consecutive mismatching samples.

module btn_debounce_lane #(
  parameter int STABLE = 4
) (
  input  logic kartclk,
  input  logic reset,
  input  logic tick,
  input  logic samp,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam logic [3:0] CMAX = 4'(STABLE - 1);

  logic [3:0] cnt;
  logic       flip;

  // cnt never exceeds CMAX, so equality is the acceptance condition
  assign flip = tick && (samp != level) && (cnt == CMAX);
  assign rise = flip & samp;
  assign fall = flip & ~samp;

  always_ff @(posedge kartclk) begin
    if (reset) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (tick) begin
      if (samp == level) begin
        cnt <= '0;
      end else if (cnt < CMAX) begin
        cnt <= cnt + 4'd1;
      end else begin
        level <= samp;
        cnt   <= '0;
      end
    end
  end
endmodule

module btn_debounce #(
  parameter int NBTN   = 4,
  parameter int STABLE = 4
) (
  input  logic            kartclk,
  input  logic            reset,
  input  logic            ffclk,
  input  logic [NBTN-1:0] btn,
  output logic [NBTN-1:0] btn_level,
  output logic [NBTN-1:0] btn_press,
  output logic [NBTN-1:0] btn_release,
  output logic            press_any,
  output logic [3:0]      press_id
);
  logic [NBTN-1:0] b_s1, b_s2, rise, fall;
  logic            f_s1, f_s2, f_s3, tick;
  logic [3:0]      id_nxt;

  always_ff @(posedge kartclk) begin
    if (reset) begin
      b_s1 <= '0;
      b_s2 <= '0;
      f_s1 <= 1'b0;
      f_s2 <= 1'b0;
      f_s3 <= 1'b0;
    end else begin
      b_s1 <= btn;
      b_s2 <= b_s1;
      f_s1 <= ffclk;
      f_s2 <= f_s1;
      f_s3 <= f_s2;
    end
  end

  // one strobe per ffclk rising edge
  assign tick = f_s2 & ~f_s3;

  for (genvar i = 0; i < NBTN; i++) begin : g_lane
    btn_debounce_lane #(.STABLE(STABLE)) u_lane (
      .kartclk (kartclk),
      .reset   (reset),
      .tick    (tick),
      .samp    (b_s2[i]),
      .level   (btn_level[i]),
      .rise    (rise[i]),
      .fall    (fall[i])
    );
  end

  always_comb begin
    id_nxt = '0;
    for (int i = NBTN - 1; i >= 0; i--)
      if (rise[i]) id_nxt = 4'(i);
  end

  always_ff @(posedge kartclk) begin
    if (reset) begin
      btn_press   <= '0;
      btn_release <= '0;
      press_any   <= 1'b0;
      press_id    <= '0;
    end else begin
      btn_press   <= rise;
      btn_release <= fall;
      press_any   <= |rise;
      press_id    <= id_nxt;
    end
  end
endmodule
